// File: rtl/div_controller.sv
// div_controller: multi-cycle shift-subtract sequencer for MIPS DIV/DIVU.
// Produces {HI = remainder, LO = quotient} for the EX stage HI/LO write path.
// One quotient bit is retired per RUN cycle. The result is held in DONE
// until EX drops start or the pipeline annuls the operation.
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               annul,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   operand1,
  input  logic [WIDTH-1:0]   operand2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Two's complement negation at operand width.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  logic [CW-1:0]      count_r;
  // Partial remainder: it always stays below the divisor, so WIDTH bits
  // hold it; the extra sign bit only exists in the trial difference.
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;
  logic               busy_r;

  logic               op1_neg_s;
  logic               op2_neg_s;
  logic [WIDTH-1:0]   op1_abs_s;
  logic [WIDTH-1:0]   op2_abs_s;
  logic               dvs_zero_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;

  // Operand sign/magnitude decode for the load edge.
  always_comb begin
    op1_neg_s  = signed_div & operand1[WIDTH-1];
    op2_neg_s  = signed_div & operand2[WIDTH-1];
    op1_abs_s  = operand1;
    op2_abs_s  = operand2;
    if (op1_neg_s) begin
      op1_abs_s = twos_neg(operand1);
    end else begin
      op1_abs_s = operand1;
    end
    if (op2_neg_s) begin
      op2_abs_s = twos_neg(operand2);
    end else begin
      op2_abs_s = operand2;
    end
    dvs_zero_s = (operand2 == {WIDTH{1'b0}});
  end

  // One restoring-division step plus the final sign fix-up of the result.
  always_comb begin
    shift_s   = {rem_r, quo_r[WIDTH-1]};
    trial_s   = shift_s - {1'b0, dvs_r};
    rem_fix_s = rem_r;
    quo_fix_s = quo_r;
    if (neg_r_r) begin
      rem_fix_s = twos_neg(rem_r);
    end else begin
      rem_fix_s = rem_r;
    end
    if (neg_q_r) begin
      quo_fix_s = twos_neg(quo_r);
    end else begin
      quo_fix_s = quo_r;
    end
  end

  // Sequencer FSM with all datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          if (start && !annul) begin
            busy_r  <= 1'b1;
            count_r <= {CW{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            if (dvs_zero_s) begin
              state_r <= BY_ZERO;
            end else begin
              state_r <= RUN;
              quo_r   <= op1_abs_s;
              dvs_r   <= op2_abs_s;
              neg_q_r <= op1_neg_s ^ op2_neg_s;
              neg_r_r <= op1_neg_s;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        BY_ZERO: begin
          busy_r <= 1'b0;
          if (annul) begin
            state_r <= IDLE;
          end else begin
            // Divide by zero yields 0; ready follows on the next DONE cycle.
            state_r  <= DONE;
            result_r <= {(2*WIDTH){1'b0}};
          end
        end
        RUN: begin
          if (annul) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (count_r == CW'(WIDTH)) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            ready_r  <= 1'b1;
            result_r <= {rem_fix_s, quo_fix_s};
          end else begin
            if (!trial_s[WIDTH]) begin
              rem_r <= trial_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r <= shift_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            count_r <= count_r + CW'(1);
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          if (start && !annul) begin
            ready_r <= 1'b1;
          end else begin
            state_r  <= IDLE;
            ready_r  <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
          end
        end
        default: begin
          state_r  <= IDLE;
          ready_r  <= 1'b0;
          busy_r   <= 1'b0;
          result_r <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign result = result_r;
  assign ready  = ready_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_div_controller.sv
// Directed testbench for div_controller (WIDTH = 32).
module tb_div_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  div_controller #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .operand1   (operand1),
    .operand2   (operand2),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request; returns 1 unit after E0 (the edge that samples it).
  task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
    signed_div = sd;
    operand1   = a;
    operand2   = b;
    start      = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    operand1 = 32'd0; operand2 = 32'd0;
    tick();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    launch(1'b0, 32'd100, 32'd7);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      checks++;
      if (ready !== (k == 33)) begin failures++; $display("FAIL divu_ready k=%0d got=%b exp=%b", k, ready, (k == 33)); end
      checks++;
      if (busy !== (k < 33)) begin failures++; $display("FAIL divu_busy k=%0d got=%b exp=%b", k, busy, (k < 33)); end
    end
    checks++;
    if (result !== {32'h00000002, 32'h0000000E}) begin failures++; $display("FAIL divu_result got=%h exp=%h", result, {32'h00000002, 32'h0000000E}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || result !== {32'h00000002, 32'h0000000E}) begin
        failures++; $display("FAIL divu_hold k=%0d ready=%b result=%h exp ready=1 result=%h", k, ready, result, {32'h00000002, 32'h0000000E});
      end
    end
    start = 1'b0;
    tick();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL divu_drop_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL divu_drop_result got=%h exp=0", result); end
  endtask

  task automatic test_signed();
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [63:0] e_v [3];
    int lat;
    a_v[0] = 32'hFFFFFFF9; b_v[0] = 32'd2;        e_v[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    a_v[1] = 32'd7;        b_v[1] = 32'hFFFFFFFE; e_v[1] = {32'h00000001, 32'hFFFFFFFD};
    a_v[2] = 32'h80000000; b_v[2] = 32'hFFFFFFFF; e_v[2] = {32'h00000000, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, a_v[i], b_v[i]);
      lat = 0;
      while (ready !== 1'b1 && lat < 40) begin tick(); lat++; end
      checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency i=%0d got=%0d exp=33", i, lat); end
      checks++; if (result !== e_v[i]) begin failures++; $display("FAIL div_result i=%0d got=%h exp=%h", i, result, e_v[i]); end
      start = 1'b0;
      tick();
    end
  endtask

  task automatic test_div_zero();
    launch(1'b0, 32'd5, 32'd0);
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL dz_k0 busy=%b ready=%b exp busy=1 ready=0", busy, ready); end
    tick();
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL dz_k1 busy=%b ready=%b exp busy=0 ready=0", busy, ready); end
    tick();
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL dz_k2 busy=%b ready=%b exp busy=0 ready=1", busy, ready); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL dz_result got=%h exp=0", result); end
    start = 1'b0;
    tick();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL dz_drop_ready got=%b exp=0", ready); end
  endtask

  task automatic test_annul();
    int seen;
    int lat;
    launch(1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL annul_idle busy=%b exp=0", busy); end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ready === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL annul_no_ready ready_cycles=%0d exp=0", seen); end
    launch(1'b0, 32'd1000, 32'd3);
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 33) begin failures++; $display("FAIL annul_restart_latency got=%0d exp=33", lat); end
    checks++; if (result !== {32'd1, 32'd333}) begin failures++; $display("FAIL annul_restart_result got=%h exp=%h", result, {32'd1, 32'd333}); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    launch(1'b1, 32'hFFFFFF9C, 32'd7);
    for (int k = 1; k <= 20; k++) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
      failures++; $display("FAIL rst_mid ready=%b busy=%b result=%h exp all 0", ready, busy, result);
    end
    start = 1'b0;
    #1 reset = 1'b1;
    tick();
    launch(1'b0, 32'd9, 32'd2);
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (result !== {32'd1, 32'd4}) begin failures++; $display("FAIL rst_done_pre got=%h exp=%h", result, {32'd1, 32'd4}); end
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      failures++; $display("FAIL rst_done ready=%b result=%h exp 0/0", ready, result);
    end
    start = 1'b0;
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_operand_stability();
    int lat;
    launch(1'b1, 32'hFFFFFF9C, 32'd7);
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      operand1   = $urandom;
      operand2   = $urandom_range(0, 5);
      signed_div = ~signed_div;
      tick();
      lat++;
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL stable_latency got=%0d exp=33", lat); end
    checks++; if (result !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin failures++; $display("FAIL stable_result got=%h exp=%h", result, {32'hFFFFFFFE, 32'hFFFFFFF2}); end
    start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_operand_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
